// File: rtl/signed_seq_divider.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit per clock.
// IDLE: accept operands | CALC: one restoring step per edge | DONE: hold result until out_ready
module signed_seq_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   qmag_q, qmag_d;
  logic [W:0]     pr_q, pr_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  logic [W:0]     pr_shift;
  logic [W:0]     pr_step;
  logic           qbit;
  logic [W-1:0]   qmag_step;
  logic [W-1:0]   dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic           is_zero;
  logic           is_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      qmag_q    <= '0;
      pr_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      qmag_q    <= qmag_d;
      pr_q      <= pr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qmag_d    = qmag_q;
    pr_d      = pr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    // Partial remainder never exceeds W bits after a step, so the shift drops nothing.
    pr_shift  = (W+1)'({pr_q, dvd_q[W-1]});
    qbit      = (pr_shift >= {1'b0, dvs_q});
    pr_step   = qbit ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
    qmag_step = W'({qmag_q, qbit});

    dvd_abs   = dividend[W-1] ? -dividend : dividend;
    dvs_abs   = divisor[W-1]  ? -divisor  : divisor;
    is_zero   = (divisor == '0);
    is_ovf    = (dividend == MIN_VAL) && (divisor == '1);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_quo_d = dividend[W-1] ^ divisor[W-1];
          neg_rem_d = dividend[W-1];
          dvd_d     = dvd_abs;
          dvs_d     = dvs_abs;
          pr_d      = '0;
          cnt_d     = '0;
          qmag_d    = '0;
          if (is_zero) begin
            quo_d   = '0;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (is_ovf) begin
            quo_d   = MIN_VAL;
            rem_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        pr_d   = pr_step;
        qmag_d = qmag_step;
        dvd_d  = dvd_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          quo_d   = neg_quo_q ? -qmag_step : qmag_step;
          rem_d   = W'(neg_rem_q ? -pr_step : pr_step);
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider (W=4): directed cases, reset abort, exhaustive sweep and random pairs
// checked against integer division in the bench.
module tb_signed_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int ops_done = 0;

  signed_seq_divider #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned just after a negedge. Issues one pair, checks latency, result,
  // optional backpressure window, and the return to IDLE after the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
    int sa, sb, qe, re, n, exp_lat;
    logic [W-1:0] qe4, re4;
    logic dbz_e, ovf_e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dbz_e = 1'b0;
    ovf_e = 1'b0;
    if (sb == 0) begin
      qe = 0; re = sa; dbz_e = 1'b1;
    end else if (sa == -(1 << (W-1)) && sb == -1) begin
      qe = -(1 << (W-1)); re = 0; ovf_e = 1'b1;
    end else begin
      qe = sa / sb; re = sa % sb;
    end
    qe4 = qe[W-1:0];
    re4 = re[W-1:0];
    exp_lat = (dbz_e || ovf_e) ? 1 : W + 1;

    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (bp == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);

    n = 1;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency %0d/%0d", sa, sb), 32'(n), 32'(exp_lat));
    chk($sformatf("quotient %0d/%0d", sa, sb), 32'(quotient), 32'(qe4));
    chk($sformatf("remainder %0d/%0d", sa, sb), 32'(remainder), 32'(re4));
    chk($sformatf("div_by_zero %0d/%0d", sa, sb), 32'(div_by_zero), 32'(dbz_e));
    chk($sformatf("overflow %0d/%0d", sa, sb), 32'(overflow), 32'(ovf_e));

    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        in_valid = 1'($urandom);
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_quotient", 32'(quotient), 32'(qe4));
        chk("bp_remainder", 32'(remainder), 32'(re4));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    ops_done++;
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd7, 4'd2, 0);
    run_op(4'h9, 4'd2, 0);
    run_op(4'd7, 4'hE, 0);
    run_op(4'h9, 4'hE, 0);
    run_op(4'h8, 4'd3, 0);
    run_op(4'd3, 4'd7, 0);
    run_op(4'd5, 4'd0, 0);
    run_op(4'h8, 4'hF, 0);
    run_op(4'hA, 4'd4, 10);

    // Abort during the second CALC cycle; no result may surface afterwards.
    in_valid  = 1'b1;
    dividend  = 4'd7;
    divisor   = 4'd3;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_op(4'd6, 4'd3, 0);

    ops_done = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), 0);
      end
    end
    chk("sweep_count", 32'(ops_done), 32'd256);

    repeat (40) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
